// File: rtl/cp0_irq_ctrl_if.sv
`default_nettype none
// cp0_irq_ctrl_if: MEM-stage side bus of the CP0 / interrupt controller.
// Revision 1.0
interface cp0_irq_ctrl_if #(
  parameter int NUM_HWINT = 6
);
  logic [4:0]           A;
  logic [31:0]          DIn;
  logic                 We;
  logic [31:0]          PC;
  logic                 BD;
  logic [4:0]           ExcCode;
  logic [NUM_HWINT-1:0] HWInt;
  logic                 EXLClr;
  logic                 Interrupt;
  logic [31:0]          EPC;
  logic [31:0]          DOut;

  modport master (
    output A, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
    input  Interrupt, EPC, DOut
  );

  modport slave (
    input  A, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
    output Interrupt, EPC, DOut
  );
endinterface
`default_nettype wire

// File: rtl/cp0_irq_ctrl.sv
`default_nettype none
// cp0_irq_ctrl: CP0 (SR/Cause/EPC/PRId) and level/edge interrupt controller beside MEM.
// Revision 1.0
module cp0_irq_ctrl #(
  parameter int          NUM_HWINT = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000000,
  parameter logic [31:0] PRID      = 32'h4255_4141
) (
  input  logic           clk,
  input  logic           reset,
  cp0_irq_ctrl_if.slave  bus
);
  localparam logic [5:0] c_LINE_MASK = 6'((7'd1 << NUM_HWINT) - 7'd1);
  localparam logic [5:0] c_EDGE      = EDGE_MASK & c_LINE_MASK;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;
  logic [5:0]  r_hwint_q;

  logic [5:0]  w_hwint;
  logic [5:0]  w_w1c;
  logic [5:0]  w_ip_next;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_take;
  logic        w_wr;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc_victim;

  assign w_hwint   = 6'(bus.HWInt) & c_LINE_MASK;
  assign w_int_req = r_ie & ~r_exl & (|(r_ip & r_im));
  assign w_exc_req = ~r_exl & (bus.ExcCode != 5'd0);
  assign w_take    = w_int_req | w_exc_req;
  // A write from the victim instruction never commits.
  assign w_wr      = bus.We & ~w_take;
  assign w_w1c     = (w_wr && bus.A == 5'd13) ? (bus.DIn[15:10] & c_EDGE) : 6'd0;

  for (genvar i = 0; i < 6; i++) begin : g_ip
    assign w_ip_next[i] = c_LINE_MASK[i] &
                          (c_EDGE[i] ? ((r_ip[i] & ~w_w1c[i]) | (w_hwint[i] & ~r_hwint_q[i]))
                                     : w_hwint[i]);
  end

  assign w_epc_victim = (bus.BD ? (bus.PC - 32'd4) : bus.PC) & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
      r_hwint_q  <= 6'd0;
    end else begin
      r_ip      <= w_ip_next;
      r_hwint_q <= w_hwint;
      if (w_take) begin
        r_exl      <= 1'b1;
        r_bd       <= bus.BD;
        r_exc_code <= w_int_req ? 5'd0 : bus.ExcCode;
        r_epc      <= w_epc_victim;
      end else begin
        if (bus.EXLClr) begin
          r_exl <= 1'b0;
        end
        if (w_wr && bus.A == 5'd12) begin
          r_im  <= bus.DIn[15:10] & c_LINE_MASK;
          r_exl <= bus.DIn[1];
          r_ie  <= bus.DIn[0];
        end
        if (w_wr && bus.A == 5'd14) begin
          r_epc <= {bus.DIn[31:2], 2'b00};
        end
      end
    end
  end

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'b00};

  always_comb begin
    bus.DOut = 32'd0;
    case (bus.A)
      5'd12:   bus.DOut = w_sr;
      5'd13:   bus.DOut = w_cause;
      5'd14:   bus.DOut = r_epc;
      5'd15:   bus.DOut = PRID;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.Interrupt = w_take;
  assign bus.EPC       = r_epc;
endmodule
`default_nettype wire

// File: tb/tb_cp0_irq_ctrl.sv
`default_nettype none
// tb_cp0_irq_ctrl: directed scenarios plus random traffic checked against a behavioural CP0 model.
// Revision 1.0
module tb_cp0_irq_ctrl;
  localparam int          NH   = 4;
  localparam logic [5:0]  EDGE = 6'b001010;
  localparam logic [31:0] PID  = 32'h4255_4141;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_irq_ctrl_if #(.NUM_HWINT(NH)) bus ();

  cp0_irq_ctrl #(.NUM_HWINT(NH), .EDGE_MASK(EDGE), .PRID(PID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: registers held as plain fields, IP/IM as per-line bits.
  bit          m_im[6];
  bit          m_ip[6];
  bit          m_prev[6];
  bit          m_ie, m_exl, m_bd;
  int unsigned m_code;
  logic [31:0] m_epc;

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      m_im[i] = 0; m_ip[i] = 0; m_prev[i] = 0;
    end
    m_ie = 0; m_exl = 0; m_bd = 0; m_code = 0; m_epc = 0;
  endfunction

  function automatic logic [31:0] m_sr();
    logic [31:0] v = 0;
    for (int i = 0; i < NH; i++) if (m_im[i]) v += 32'd1 << (10 + i);
    if (m_exl) v += 2;
    if (m_ie)  v += 1;
    return v;
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] v = 0;
    for (int i = 0; i < NH; i++) if (m_ip[i]) v += 32'd1 << (10 + i);
    v += 32'(m_code) * 4;
    if (m_bd) v += 32'h8000_0000;
    return v;
  endfunction

  function automatic bit m_int_req();
    bit any = 0;
    for (int i = 0; i < NH; i++) if (m_ip[i] && m_im[i]) any = 1;
    return m_ie && !m_exl && any;
  endfunction

  function automatic bit m_take();
    return m_int_req() || (!m_exl && bus.ExcCode != 0);
  endfunction

  function automatic logic [31:0] m_dout();
    case (int'(bus.A))
      12:      return m_sr();
      13:      return m_cause();
      14:      return m_epc;
      15:      return PID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_update();
    bit ir, take, wr, hw, clr;
    if (reset) begin
      model_reset();
      return;
    end
    ir   = m_int_req();
    take = m_take();
    wr   = bus.We && !take;
    for (int i = 0; i < NH; i++) begin
      hw = bus.HWInt[i];
      if (EDGE[i]) begin
        clr      = wr && bus.A == 13 && bus.DIn[10+i];
        m_ip[i]  = (m_ip[i] && !clr) || (hw && !m_prev[i]);
      end else begin
        m_ip[i]  = hw;
      end
      m_prev[i] = hw;
    end
    if (take) begin
      m_exl  = 1;
      m_bd   = bus.BD;
      m_code = ir ? 0 : int'(bus.ExcCode);
      m_epc  = (bus.BD ? bus.PC - 4 : bus.PC);
      m_epc  = m_epc - (m_epc % 4);
    end else begin
      if (bus.EXLClr) m_exl = 0;
      if (wr && bus.A == 12) begin
        for (int i = 0; i < NH; i++) m_im[i] = bus.DIn[10+i];
        m_exl = bus.DIn[1];
        m_ie  = bus.DIn[0];
      end
      if (wr && bus.A == 14) m_epc = bus.DIn - (bus.DIn % 4);
    end
  endfunction

  // Inputs are driven just after negedge; outputs compared, then one clock taken.
  task automatic step();
    #1;
    if (!reset) begin
      check_eq("intr", 32'(bus.Interrupt), 32'(m_take()));
      check_eq("epc",  bus.EPC, m_epc);
      check_eq("dout", bus.DOut, m_dout());
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.We = 0; bus.ExcCode = 0; bus.EXLClr = 0; bus.BD = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.We = 1; bus.A = a; bus.DIn = d;
    step();
    bus.We = 0;
  endtask

  initial begin
    reset = 1;
    bus.A = 0; bus.DIn = 0; bus.PC = 0; bus.HWInt = 0;
    idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step();
    reset = 0;
    bus.A = 12; #1;
    check_eq("rst_sr", bus.DOut, 32'd0);
    check_eq("rst_epc", bus.EPC, 32'd0);
    check_eq("rst_int", 32'(bus.Interrupt), 32'd0);

    // Level interrupt on line 0.
    mtc0(5'd12, 32'h0000_0401);
    bus.HWInt = 4'b0001; bus.A = 13; #1;
    check_eq("lvl_same_cycle", 32'(bus.Interrupt), 32'd0);
    step();
    bus.PC = 32'h3010; #1;
    check_eq("lvl_int", 32'(bus.Interrupt), 32'd1);
    step();
    #1;
    check_eq("lvl_epc", bus.EPC, 32'h3010);
    check_eq("lvl_cause", bus.DOut, 32'h0000_0400);
    check_eq("lvl_exl_blocks", 32'(bus.Interrupt), 32'd0);
    bus.A = 12; #1;
    check_eq("lvl_sr", bus.DOut, 32'h0000_0403);
    step();

    // Delay-slot overflow exception.
    bus.HWInt = 0; step();
    bus.EXLClr = 1; step();
    bus.EXLClr = 0; bus.ExcCode = 12; bus.BD = 1; bus.PC = 32'h3024; #1;
    check_eq("ds_int", 32'(bus.Interrupt), 32'd1);
    step();
    idle(); bus.A = 13; #1;
    check_eq("ds_cause", bus.DOut, 32'h8000_0030);
    check_eq("ds_epc", bus.EPC, 32'h3020);
    bus.EXLClr = 1; step();
    bus.EXLClr = 0; bus.A = 12; #1;
    check_eq("ds_exlclr", bus.DOut, 32'h0000_0401);

    // Edge latch on line 1 with IE = 0.
    mtc0(5'd12, 32'd0);
    bus.HWInt = 4'b0010; step();
    bus.HWInt = 0;
    repeat (100) step();
    bus.A = 13; #1;
    check_eq("edge_hold", bus.DOut & 32'h800, 32'h800);
    mtc0(5'd13, 32'h800);
    bus.A = 13; #1;
    check_eq("edge_w1c", bus.DOut & 32'h800, 32'h0);
    bus.HWInt = 4'b0010;
    mtc0(5'd13, 32'h800);
    bus.HWInt = 0; bus.A = 13; #1;
    check_eq("edge_set_wins", bus.DOut & 32'h800, 32'h800);

    // Interrupt beats exception, victim write dropped.
    mtc0(5'd12, 32'h0000_0801);
    bus.ExcCode = 4; bus.PC = 32'h4000; bus.We = 1; bus.A = 14; bus.DIn = 32'h1234; #1;
    check_eq("pri_int", 32'(bus.Interrupt), 32'd1);
    step();
    idle(); bus.A = 13; #1;
    check_eq("pri_code", bus.DOut & 32'h7C, 32'h0);
    check_eq("pri_epc", bus.EPC, 32'h4000);
    mtc0(5'd13, 32'h800);

    // Masking and implemented-width checks.
    mtc0(5'd12, 32'h0000_0001);
    bus.HWInt = 4'b1111; step(); step();
    #1;
    check_eq("mask_noint", 32'(bus.Interrupt), 32'd0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    bus.A = 12; #1;
    check_eq("sr_width", bus.DOut, 32'h0000_3C03);
    bus.A = 15; #1;
    check_eq("prid", bus.DOut, PID);
    bus.A = 13; #1;
    check_eq("cause_width", bus.DOut, 32'h0000_3C00);
    step();

    // Reset while in service with latched edges.
    reset = 1; step();
    reset = 0; bus.HWInt = 0;
    bus.A = 12; #1; check_eq("rst2_sr", bus.DOut, 32'd0);
    bus.A = 13; #1; check_eq("rst2_cause", bus.DOut, 32'd0);
    bus.A = 14; #1; check_eq("rst2_epc", bus.DOut, 32'd0);
    check_eq("rst2_int", 32'(bus.Interrupt), 32'd0);
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      bus.We     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: bus.A = 12;
        1: bus.A = 13;
        2: bus.A = 14;
        3: bus.A = 15;
        default: bus.A = 5'($urandom);
      endcase
      bus.DIn     = $urandom;
      bus.PC      = $urandom;
      bus.BD      = 1'($urandom);
      bus.ExcCode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      bus.EXLClr  = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NH; i++)
        if ($urandom_range(0, 3) == 0) bus.HWInt[i] = ~bus.HWInt[i];
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
Parametrised coprocessor-0 and interrupt controller for the 5-stage MIPS pipeline. It sits beside the MEM stage. It holds SR, Cause, EPC and PRId, and decides on every cycle whether the instruction in MEM is the victim of an exception or interrupt. It supports 1..6 hardware interrupt lines, each configurable as level-sensitive or edge-latched, so a wider set of devices can attach than fixed level-only lines allow.

Parameters:
NUM_HWINT, 6, number of hardware interrupt lines (1..6); they map to IP/IM bits [10+NUM_HWINT-1:10].
EDGE_MASK, 6'b000000, per-line mode: bit i = 1 means line i is edge-latched, 0 means level.
PRID, 32'h4255_4141, read-only value of PRId (reg 15).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
A  in  5  CP0 register number for mfc0/mtc0 (IR_M rd field).
DIn  in  32  mtc0 write data (forwarded rt).
We  in  1  mtc0 write enable.
PC  in  32  PC of the instruction in MEM.
BD  in  1  MEM instruction is in a branch delay slot.
ExcCode  in  5  synchronous exception code from the pipeline; 0 means none.
HWInt  in  NUM_HWINT  raw device interrupt lines.
EXLClr  in  1  eret retiring; clears EXL.
Interrupt  out  1  take exception or interrupt this cycle; flushes the pipeline and redirects the PC.
EPC  out  32  current EPC (eret target).
DOut  out  32  mfc0 read data.

Behaviour:
- Reset values: SR = 0, Cause = 0, EPC = 0, internal HWInt_q = 0. Outputs at reset: Interrupt = 0, EPC = 0, DOut per A.
- SR layout: IM[15:10], EXL bit 1, IE bit 0; all other bits read 0.
- Cause layout: BD bit 31, IP[15:10], ExcCode[6:2]; all other bits read 0. Bits of IP/IM at or above NUM_HWINT read 0 and are not writable.
- IP update, every cycle:
  - Level line: IP[i] <= HWInt[i], a one-cycle registered copy.
  - Edge line: IP[i] <= IP[i] | (HWInt[i] & ~HWInt_q[i]). The bit stays set until software clears it.
- IntReq = IE & ~EXL & |(IP & IM), based on registered IP.
- ExcReq = ~EXL & (ExcCode != 0).
- Interrupt = IntReq | ExcReq, combinational. Hardware interrupt has priority over a synchronous exception.
- On a clock edge with Interrupt = 1:
  - EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= 0 if IntReq, else ExcCode.
  - EPC <= (BD ? PC-4 : PC) with bits [1:0] forced to 0.
- EXLClr = 1: EXL <= 0 next edge. EXLClr and Interrupt cannot coincide, because Interrupt requires EXL = 0. If they do, Interrupt wins.
- mtc0 (We = 1, Interrupt = 0):
  - A = 12: SR <= DIn, masked to the legal bits.
  - A = 13: write-1-to-clear on IP bits of edge lines only. All other Cause bits are read-only.
  - A = 14: EPC <= {DIn[31:2], 2'b00}.
  - A = 15 or others: ignored.
  - We with Interrupt = 1: the write is dropped, because the victim instruction does not commit.
- Edge-line set and W1C clear in the same cycle: the set wins, so the bit stays 1.
- mfc0: DOut returns the register selected by A (12/13/14/15). Any other A returns 0. Reads are combinational, and a write becomes visible the cycle after.
- Reset mid-service (EXL = 1): everything returns to reset values; any pending edge latches are lost.

Test Plan:
- Level interrupt: SR = 0x0000_0401, assert HWInt[0] at cycle N → IP[10] = 1 at N+1; Interrupt = 1 at N+1 with PC = 0x3010, BD = 0 → EPC = 0x3010, Cause.ExcCode = 0, EXL = 1. Interrupt is 0 afterwards while EXL = 1.
- Delay-slot exception: ExcCode = 12 (Ov), BD = 1, PC = 0x3024 → EPC = 0x3020, Cause = 0x8000_0030; EXLClr → EXL = 0 next cycle.
- Edge latch (EDGE_MASK = 6'b000010): a 1-cycle pulse on HWInt[1] with IE = 0 → IP[11] stays 1 for 100 cycles. mtc0 Cause with 0x800 → IP[11] = 0. Pulse and W1C in the same cycle → IP[11] stays 1.
- Priority and drop: HWInt pending and enabled, ExcCode = 4, We = 1 to EPC with 0x1234 → Cause.ExcCode = 0, EPC = victim PC, and 0x1234 is not written.
- Masking and width (NUM_HWINT = 3): HWInt = 3'b111, IM = 0 → Interrupt = 0. mtc0 SR = 0xFFFF_FFFF → SR reads 0x0000_1C03. mfc0 15 returns PRID.
- Reset while EXL = 1 with a latched edge IP → next cycle SR = Cause = EPC = 0 and Interrupt = 0.
